ov7670_config_ctrl: RTL
=======================

Name: ov7670_config_ctrl

Overview:
- Sequencer directly downstream of the OV7670 register-table ROM.
- Walks the ROM from address 0 and decodes each 16-bit entry (reg[15:8], value[7:0]).
- Hands each register write to the SCCB master through a start/ready handshake.
- Executes the delay entry 16'hFFF0 as a timed wait, stops at the end marker 16'hFFFF, then raises done.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- DELAY_MS, 10, length of the wait for an FFF0 entry, in ms.
  - DELAY_CYCLES = CLK_FREQ/1000*DELAY_MS, computed at elaboration.
  - DELAY_CYCLES must be >= 1.
- MAX_RETRY, 3, resend limit per entry; used only with CFG_NACK_RETRY_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin configuration; sampled in IDLE or DONE only.
- rom_addr  output  8  address to the config ROM.
- rom_data  input  16  ROM output; registered, valid 1 cycle after rom_addr changes.
- sccb_ready  input  1  SCCB master idle and able to accept a write.
- sccb_nack  input  1  master saw a NACK on the last write; valid on the cycle ready returns high.
- sccb_start  output  1  one-cycle request to write sccb_reg/sccb_val.
- sccb_reg  output  8  camera register address.
- sccb_val  output  8  camera register value.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  sticky: configuration complete.
- error  output  1  sticky: retries exhausted; tied 0 without CFG_NACK_RETRY_EN.

Behaviour:
- Reset values: state=IDLE, rom_addr=0, sccb_start=0, sccb_reg=0, sccb_val=0, busy=0, done=0, error=0, delay counter=0, retry counter=0.
- rst takes priority in any state. It returns the block to IDLE on the next edge and drops sccb_start immediately (no pending transaction is completed).
- States:
  - IDLE: start=1 -> rom_addr<=0, go to FETCH.
  - FETCH: one wait cycle for ROM latency -> DECODE.
  - DECODE: samples rom_data.
    - 16'hFFFF -> DONE.
    - 16'hFFF0 -> DELAY, counter cleared.
    - Otherwise latch sccb_reg<=rom_data[15:8], sccb_val<=rom_data[7:0] -> REQ.
  - REQ: wait for sccb_ready=1, then assert sccb_start for exactly 1 cycle -> WAIT_ACCEPT.
  - WAIT_ACCEPT: wait for sccb_ready=0.
    - If ready is still high 1 cycle after the start pulse, the master is non-compliant; remain here.
    - ready=0 -> WAIT_DONE.
  - WAIT_DONE: wait for sccb_ready=1 -> NEXT.
  - DELAY: count 0..DELAY_CYCLES-1; on terminal count -> NEXT.
  - NEXT:
    - rom_addr==255 -> DONE. No wrap; 256 entries maximum.
    - Else rom_addr<=rom_addr+1 -> FETCH.
  - DONE: done=1.
    - start=1 -> clear done and error, rom_addr<=0 -> FETCH.
- busy is asserted in FETCH, DECODE, REQ, WAIT_ACCEPT, WAIT_DONE, DELAY and NEXT.
- start is ignored while busy=1.
- sccb_reg/sccb_val are held stable from DECODE until the next DECODE.
- Per-write overhead: at least 4 cycles (NEXT, FETCH, DECODE, REQ) plus SCCB transaction time.
- A reset entry (12_80) followed by FFF0 guarantees the sensor gets DELAY_MS after its soft reset.

Optional Feature:
- CFG_NACK_RETRY_EN defined:
  - On entry to NEXT from WAIT_DONE with sccb_nack=1 and retry<MAX_RETRY: retry++, go back to REQ with the same entry.
  - If retry==MAX_RETRY: error<=1, go to DONE (done=1).
  - The retry counter clears whenever rom_addr advances.
- CFG_NACK_RETRY_EN undefined:
  - sccb_nack is ignored and error is constant 0.
  - The retry counter is not synthesized.

Test Plan:
- ROM model {0:1280, 1:FFF0, 2:1204, 3:FFFF}; CLK_FREQ=1000, DELAY_MS=10; master drops ready 1 cycle after start and restores it 20 cycles later; pulse start -> two sccb_start pulses (12/80 then 12/04) separated by at least 10 DELAY cycles; done=1; busy=0; rom_addr=3.
- Reset mid-write: assert rst in WAIT_DONE -> next cycle state IDLE, sccb_start=0, rom_addr=0, done=0; no further start pulses until a new start.
- Master holds sccb_ready=0 for 100 cycles before the first write -> no sccb_start pulse until ready rises; exactly one pulse of width 1.
- ROM of 256 non-marker entries -> 256 writes, rom_addr stops at 255, done=1, no wrap to 0.
- start pulsed while busy -> ignored (no restart).
- start pulsed in DONE -> rewrite the full table from addr 0.
- With CFG_NACK_RETRY_EN and MAX_RETRY=3, sccb_nack=1 on every write -> entry 0 sent 4 times, then error=1, done=1.
- Same stimulus without the macro -> all entries sent once, error=0.

Source files
------------

// File: rtl/ov7670_config_ctrl.sv
// OV7670 configuration sequencer: walks the register-table ROM and hands each entry to the SCCB master.
// Optional build macro CFG_NACK_RETRY_EN enables per-entry resend on NACK and the sticky error flag.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for start after reset
// FETCH       | ROM address presented, waiting out the ROM register
// DECODE      | classify rom_data: end marker, delay marker or register write
// REQ         | waiting for sccb_ready, then issue the one-cycle sccb_start
// WAIT_ACCEPT | waiting for the master to drop sccb_ready
// WAIT_DONE   | waiting for the master to raise sccb_ready again
// DELAY       | timed wait for an FFF0 entry
// NEXT        | advance rom_addr or finish at the last address
// DONE        | table complete; start rewrites it from address 0
module ov7670_config_ctrl #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DELAY_MS  = 10,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    input  logic        sccb_ready,
    input  logic        sccb_nack,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_FETCH       = 4'd1;
    localparam logic [3:0] S_DECODE      = 4'd2;
    localparam logic [3:0] S_REQ         = 4'd3;
    localparam logic [3:0] S_WAIT_ACCEPT = 4'd4;
    localparam logic [3:0] S_WAIT_DONE   = 4'd5;
    localparam logic [3:0] S_DELAY       = 4'd6;
    localparam logic [3:0] S_NEXT        = 4'd7;
    localparam logic [3:0] S_DONE        = 4'd8;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;

    localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
    localparam int DCW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [DCW-1:0] DELAY_LAST = DCW'(DELAY_CYCLES - 1);

    logic [3:0]     state_q, state_d;
    logic [7:0]     rom_addr_q, rom_addr_d;
    logic           sccb_start_q, sccb_start_d;
    logic [7:0]     sccb_reg_q, sccb_reg_d;
    logic [7:0]     sccb_val_q, sccb_val_d;
    logic           done_q, done_d;
    logic [DCW-1:0] dly_q, dly_d;

`ifdef CFG_NACK_RETRY_EN
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRY);

    logic [RCW-1:0] retry_q, retry_d;
    logic           error_q, error_d;
`else
    logic unused_nack;
    assign unused_nack = sccb_nack ^ MAX_RETRY[0];
`endif

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_start_d = 1'b0;
        sccb_reg_d   = sccb_reg_q;
        sccb_val_d   = sccb_val_q;
        done_d       = done_q;
        dly_d        = dly_q;
`ifdef CFG_NACK_RETRY_EN
        retry_d      = retry_q;
        error_d      = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rom_addr_d = 8'd0;
                    state_d    = S_FETCH;
`ifdef CFG_NACK_RETRY_EN
                    retry_d    = '0;
`endif
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data == ROM_END) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rom_data == ROM_DELAY) begin
                    dly_d   = '0;
                    state_d = S_DELAY;
                end else begin
                    sccb_reg_d = rom_data[15:8];
                    sccb_val_d = rom_data[7:0];
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (sccb_ready) begin
                    sccb_start_d = 1'b1;
                    state_d      = S_WAIT_ACCEPT;
                end
            end
            // A master that never drops ready parks the sequencer here.
            S_WAIT_ACCEPT: begin
                if (!sccb_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (sccb_ready) begin
                    state_d = S_NEXT;
`ifdef CFG_NACK_RETRY_EN
                    if (sccb_nack) begin
                        if (retry_q < RETRY_LIMIT) begin
                            retry_d = retry_q + RCW'(1);
                            state_d = S_REQ;
                        end else begin
                            error_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
`endif
                end
            end
            S_DELAY: begin
                if (dly_q == DELAY_LAST) state_d = S_NEXT;
                else                     dly_d   = dly_q + DCW'(1);
            end
            S_NEXT: begin
                if (rom_addr_q == 8'hFF) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rom_addr_d = rom_addr_q + 8'd1;
                    state_d    = S_FETCH;
`ifdef CFG_NACK_RETRY_EN
                    retry_d    = '0;
`endif
                end
            end
            S_DONE: begin
                if (start) begin
                    done_d     = 1'b0;
                    rom_addr_d = 8'd0;
                    state_d    = S_FETCH;
`ifdef CFG_NACK_RETRY_EN
                    error_d    = 1'b0;
                    retry_d    = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= 8'd0;
            sccb_start_q <= 1'b0;
            sccb_reg_q   <= 8'd0;
            sccb_val_q   <= 8'd0;
            done_q       <= 1'b0;
            dly_q        <= '0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            sccb_start_q <= sccb_start_d;
            sccb_reg_q   <= sccb_reg_d;
            sccb_val_q   <= sccb_val_d;
            done_q       <= done_d;
            dly_q        <= dly_d;
        end
    end

`ifdef CFG_NACK_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= '0;
            error_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            error_q <= error_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Reset kills a pending request in the same cycle rather than one edge later.
    assign sccb_start = sccb_start_q & ~rst;
    assign rom_addr   = rom_addr_q;
    assign sccb_reg   = sccb_reg_q;
    assign sccb_val   = sccb_val_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = done_q;

endmodule
